// File: rtl/serial_word_loader.sv
// -----------------------------------------------------------------------------
// serial_word_loader
//
// Purpose:
//   Upstream stage for a WIDTH-bit load-enabled register (Register32bits).
//   Assembles a serial bit stream, MSB first, into a WIDTH-bit word and then
//   presents it on D with a one-cycle load strobe (enable). The strobe is
//   gated by a ready signal from the downstream side. The finished word is
//   held until downstream accepts it. Accepted words are counted.
//
// Ports:
//   clk         in   1      system clock, all state changes on rising edge
//   reset       in   1      synchronous, active-high reset (highest priority)
//   start       in   1      begin, or restart, assembly of a new word
//   bit_in      in   1      serial data bit, MSB first
//   bit_valid   in   1      bit_in is valid this cycle (used in SHIFT only)
//   load_ready  in   1      downstream may load this cycle
//   D           out  WIDTH  assembled word, feeds the register's D input
//   enable      out  1      load strobe, feeds the register's enable input
//   busy        out  1      high while in SHIFT or LOAD
//   word_count  out  CNT_W  words loaded since reset, wraps silently
// -----------------------------------------------------------------------------
module serial_word_loader #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             load_ready,
    output logic [WIDTH-1:0] D,
    output logic             enable,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);

    // Bit counter only needs to reach WIDTH-1; the final shift moves to LOAD.
    localparam int BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [BCNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]   r_word_count;
    logic               w_enable;

    // The strobe must be combinational so the register captures D in the very
    // cycle downstream signals ready. A simultaneous start wins and drops the
    // pending word, so it suppresses the strobe.
    assign w_enable = (r_state == ST_LOAD) & load_ready & ~start;

    assign enable     = w_enable;
    assign busy       = (r_state != ST_IDLE);
    assign D          = r_shift;
    assign word_count = r_word_count;

    // Word assembly FSM, shift register, bit counter and loaded-word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_word_count <= '0;
        end else if (start) begin
            // Start and restart behave identically in every state: any partial
            // or unloaded word is discarded, and a bit offered this cycle is
            // ignored because it belongs to the abandoned word.
            r_state      <= ST_SHIFT;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_word_count <= r_word_count;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state      <= ST_IDLE;
                    r_shift      <= r_shift;
                    r_bit_cnt    <= r_bit_cnt;
                    r_word_count <= r_word_count;
                end
                ST_SHIFT: begin
                    r_word_count <= r_word_count;
                    if (bit_valid) begin
                        r_shift   <= {r_shift[WIDTH-2:0], bit_in};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end else begin
                        // Stall: no timeout, the word simply waits for more bits.
                        r_state   <= ST_SHIFT;
                        r_shift   <= r_shift;
                        r_bit_cnt <= r_bit_cnt;
                    end
                end
                ST_LOAD: begin
                    // D stays frozen until the word is accepted or abandoned.
                    r_shift   <= r_shift;
                    r_bit_cnt <= r_bit_cnt;
                    if (w_enable) begin
                        r_state      <= ST_IDLE;
                        r_word_count <= r_word_count + 1'b1;
                    end else begin
                        r_state      <= ST_LOAD;
                        r_word_count <= r_word_count;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_shift      <= r_shift;
                    r_bit_cnt    <= r_bit_cnt;
                    r_word_count <= r_word_count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// -----------------------------------------------------------------------------
// tb_serial_word_loader
//
// Drives two loaders (CNT_W=8 and CNT_W=2) with identical stimulus. Stimulus
// pushes the expected word and post-load counts into a queue for every word
// that must be loaded; a monitor pops an entry on every enable pulse and
// compares D, the load counts and a behavioural Register32bits model.
// -----------------------------------------------------------------------------
module tb_serial_word_loader;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset, start, bit_in, bit_valid, load_ready;
    logic [31:0] d_a, d_b;
    logic        en_a, en_b, busy_a, busy_b;
    logic [7:0]  wc_a;
    logic [1:0]  wc_b;

    always #5 clk = ~clk;

    serial_word_loader #(.WIDTH(WIDTH), .CNT_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .load_ready(load_ready),
        .D(d_a), .enable(en_a), .busy(busy_a), .word_count(wc_a)
    );

    serial_word_loader #(.WIDTH(WIDTH), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .load_ready(load_ready),
        .D(d_b), .enable(en_b), .busy(busy_b), .word_count(wc_b)
    );

    // Behavioural Register32bits downstream of loader A: Q loads D on enable.
    logic [31:0] reg_q;
    always_ff @(posedge clk) begin
        if (reset) reg_q <= 32'h0;
        else if (en_a) reg_q <= d_a;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] word;
        logic [7:0]  c8;
        logic [1:0]  c2;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_c8;
    logic [1:0]  exp_c2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] w);
        exp_c8 = exp_c8 + 8'd1;
        exp_c2 = exp_c2 + 2'd1;
        sb_q.push_back('{word: w, c8: exp_c8, c2: exp_c2});
    endtask

    // One start cycle; junk_bit offers a valid bit that must be discarded.
    task automatic do_start(input logic junk_bit);
        start = 1'b1;
        bit_valid = junk_bit;
        bit_in = 1'b1;
        tick();
        start = 1'b0;
        bit_valid = 1'b0;
    endtask

    // Send bits lo..hi-1 of w, MSB first, one per cycle.
    task automatic send_bits(input logic [31:0] w, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bit_in = w[31-i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    // Monitor: every enable pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (en_a === 1'b1 || en_b === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_enable: got en_a=%b en_b=%b expected no load (t=%0t)",
                             en_a, en_b, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("load_D", d_a, mon_e.word);
                    check("load_D_b", d_b, mon_e.word);
                    check("load_en_b", 32'(en_b), 32'd1);
                    @(posedge clk);
                    #1;
                    check("load_count", 32'(wc_a), 32'(mon_e.c8));
                    check("load_count_b", 32'(wc_b), 32'(mon_e.c2));
                    check("reg_Q", reg_q, mon_e.word);
                    check("enable_one_cycle", 32'(en_a), 32'd0);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] words6 [5];
    logic [1:0]  seq6   [5];
    int          t0;

    initial begin
        words6 = '{32'h00000001, 32'h12345678, 32'hCAFEF00D, 32'h7FFFFFFE, 32'h0F0F0F0F};
        seq6   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; load_ready = 1'b1;
        exp_c8 = 8'd0; exp_c2 = 2'd0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_D", d_a, 32'h0);
        check("rst_enable", 32'(en_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_count", 32'(wc_a), 32'd0);

        // bit_valid is ignored in IDLE
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (2) tick();
        bit_valid = 1'b0;
        check("idle_D_hold", d_a, 32'h0);
        check("idle_busy", 32'(busy_a), 32'd0);

        // 1: all ones, immediate load
        push_exp(32'hFFFFFFFF);
        do_start(1'b0);
        check("t1_busy_shift", 32'(busy_a), 32'd1);
        send_bits(32'hFFFFFFFF, 0, 32);
        check("t1_enable", 32'(en_a), 32'd1);
        check("t1_D", d_a, 32'hFFFFFFFF);
        tick();
        check("t1_busy_fall", 32'(busy_a), 32'd0);
        check("t1_count", 32'(wc_a), 32'd1);
        check("t1_Qcomp", ~reg_q, 32'h0);

        // 2: 3-cycle stall mid-word, load delayed exactly 3 cycles
        push_exp(32'h80000801);
        do_start(1'b0);
        t0 = cyc;
        send_bits(32'h80000801, 0, 16);
        for (int k = 0; k < 3; k++) begin
            check("t2_stall_D", d_a, 32'h00008000);
            check("t2_stall_en", 32'(en_a), 32'd0);
            tick();
        end
        send_bits(32'h80000801, 16, 32);
        check("t2_enable", 32'(en_a), 32'd1);
        check("t2_latency", 32'(cyc - t0), 32'd35);
        tick();
        check("t2_count", 32'(wc_a), 32'd2);

        // 3: load_ready low for 5 cycles
        push_exp(32'hAAAAAAAA);
        do_start(1'b0);
        load_ready = 1'b0;
        send_bits(32'hAAAAAAAA, 0, 32);
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_en", 32'(en_a), 32'd0);
            check("t3_hold_busy", 32'(busy_a), 32'd1);
            check("t3_hold_D", d_a, 32'hAAAAAAAA);
            check("t3_hold_Q", reg_q, 32'h80000801);
            tick();
        end
        load_ready = 1'b1;
        #1;
        check("t3_enable", 32'(en_a), 32'd1);
        tick();
        check("t3_Q", reg_q, 32'hAAAAAAAA);
        check("t3_busy_fall", 32'(busy_a), 32'd0);

        // 4: restart after 10 bits, restart dropping a pending word, then a full word
        do_start(1'b0);
        send_bits(32'hFFC00000, 0, 10);
        check("t4_partial_D", d_a, 32'h000003FF);
        do_start(1'b1);
        check("t4_restart_D", d_a, 32'h0);
        check("t4_restart_busy", 32'(busy_a), 32'd1);
        load_ready = 1'b0;
        send_bits(32'h12345678, 0, 32);
        check("t4_pending_D", d_a, 32'h12345678);
        start = 1'b1; load_ready = 1'b1;
        #1;
        check("t4_start_blocks_en", 32'(en_a), 32'd0);
        tick();
        start = 1'b0;
        check("t4_drop_D", d_a, 32'h0);
        check("t4_drop_busy", 32'(busy_a), 32'd1);
        push_exp(32'h401FF805);
        send_bits(32'h401FF805, 0, 32);
        check("t4_enable", 32'(en_a), 32'd1);
        check("t4_D", d_a, 32'h401FF805);
        tick();
        check("t4_count", 32'(wc_a), 32'd4);

        // 5: reset after 20 bits
        do_start(1'b0);
        send_bits(32'hDEADBEEF, 0, 20);
        check("t5_busy_before", 32'(busy_a), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_c8 = 8'd0; exp_c2 = 2'd0;
        check("t5_D", d_a, 32'h0);
        check("t5_busy", 32'(busy_a), 32'd0);
        check("t5_count", 32'(wc_a), 32'd0);
        check("t5_count_b", 32'(wc_b), 32'd0);
        repeat (3) tick();
        check("t5_still_idle", 32'(busy_a), 32'd0);

        // 6: CNT_W=2 wrap sequence 1,2,3,0,1
        for (int k = 0; k < 5; k++) begin
            push_exp(words6[k]);
            do_start(1'b0);
            send_bits(words6[k], 0, 32);
            tick();
            check("t6_count_b", 32'(wc_b), 32'(seq6[k]));
            check("t6_count_a", 32'(wc_a), 32'(k + 1));
        end

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
